// File: rtl/clken_pkg.sv
// Shared definitions for the clock-enable monitor: FSM state encoding and
// default parameter values.
package clken_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    localparam int DEF_PERIOD_W   = 8;
    localparam int DEF_TOL        = 0;
    localparam int DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/clken_monitor_gap_counter.sv
// Saturating gap counter: counts master-clock cycles since the last enable
// pulse, clearing on every clken-high cycle and holding at all-ones.
module gap_counter
    import clken_pkg::*;
#(
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk25,
    input  logic                rst,
    input  logic                clken,
    output logic [PERIOD_W-1:0] cnt,
    output logic                saturated
);

    assign saturated = &cnt;

    always_ff @(posedge clk25) begin
        if (rst) begin
            cnt <= '0;
        end else if (clken) begin
            cnt <= '0;
        end else if (!saturated) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/clken_monitor.sv
// Clock-enable rate monitor: measures enable-to-enable periods, tracks lock
// against an expected period and latches short/long period errors.
module clken_monitor
    import clken_pkg::*;
#(
    parameter int PERIOD_W   = DEF_PERIOD_W,
    parameter int TOL        = DEF_TOL,
    parameter int LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic                clk25,
    input  logic                rst,
    input  logic                clken,
    input  logic [PERIOD_W-1:0] exp_period,
    input  logic                err_clr,
    output logic [PERIOD_W-1:0] meas_period,
    output logic                meas_valid,
    output logic                locked,
    output logic                err_short,
    output logic                err_long,
    output logic [15:0]         pulse_count
);

    localparam int WW = PERIOD_W + 1;
    localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [WW-1:0] TOL_W     = WW'(TOL);
    localparam logic [GW-1:0] LOCK_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [GW-1:0] LOCK_FULL = GW'(LOCK_COUNT);

    logic [PERIOD_W-1:0] cnt;
    logic                cnt_sat;
    logic [PERIOD_W-1:0] exp_q;
    logic [WW-1:0]       exp_w, lo, hi, period;
    logic                exp_change, timeout;

    state_t              state, state_n;
    logic [GW-1:0]       good_cnt, good_n;
    logic                fired, fired_n;
    logic [PERIOD_W-1:0] meas_period_n;
    logic                meas_valid_n, err_short_n, err_long_n;

    gap_counter #(.PERIOD_W(PERIOD_W)) u_gap (
        .clk25     (clk25),
        .rst       (rst),
        .clken     (clken),
        .cnt       (cnt),
        .saturated (cnt_sat)
    );

    // Window and observed period are one bit wider so exp_period+TOL never wraps.
    assign exp_w      = {1'b0, exp_period};
    assign hi         = exp_w + TOL_W;
    assign lo         = (exp_w > TOL_W) ? (exp_w - TOL_W) : WW'(1);
    assign period     = cnt_sat ? {1'b0, cnt} : ({1'b0, cnt} + WW'(1));
    assign exp_change = (exp_period != exp_q);
    assign timeout    = !clken && ({1'b0, cnt} >= hi) && !fired;
    assign locked     = (state == ST_LOCKED);

    always_comb begin
        state_n       = state;
        good_n        = good_cnt;
        fired_n       = clken ? 1'b0 : fired;
        meas_period_n = meas_period;
        meas_valid_n  = 1'b0;
        err_short_n   = err_short & ~err_clr;
        err_long_n    = err_long & ~err_clr;

        if (exp_change || exp_period == '0) begin
            state_n = ST_IDLE;
            good_n  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clken) state_n = ST_MEASURE;
                end
                ST_MEASURE, ST_LOCKED: begin
                    if (clken) begin
                        meas_period_n = period[PERIOD_W-1:0];
                        meas_valid_n  = 1'b1;
                        if (period < lo) begin
                            err_short_n = 1'b1;
                            good_n      = '0;
                            state_n     = ST_MEASURE;
                        end else if (period > hi) begin
                            // A timeout earlier in this gap has already reported it.
                            if (!fired) err_long_n = 1'b1;
                            good_n  = '0;
                            state_n = ST_MEASURE;
                        end else if (state == ST_MEASURE) begin
                            if (good_cnt >= LOCK_LAST) begin
                                good_n  = LOCK_FULL;
                                state_n = ST_LOCKED;
                            end else begin
                                good_n = good_cnt + 1'b1;
                            end
                        end
                    end else if (timeout) begin
                        err_long_n = 1'b1;
                        fired_n    = 1'b1;
                        good_n     = '0;
                        state_n    = ST_MEASURE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    good_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            state       <= ST_IDLE;
            good_cnt    <= '0;
            fired       <= 1'b0;
            exp_q       <= exp_period;
            meas_period <= '0;
            meas_valid  <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            pulse_count <= '0;
        end else begin
            state       <= state_n;
            good_cnt    <= good_n;
            fired       <= fired_n;
            exp_q       <= exp_period;
            meas_period <= meas_period_n;
            meas_valid  <= meas_valid_n;
            err_short   <= err_short_n;
            err_long    <= err_long_n;
            if (clken) pulse_count <= pulse_count + 16'd1;
        end
    end

endmodule
